// File: rtl/id_ex_fwd_stage.sv
// ID/EX pipeline register with EX/MEM and MEM/WB operand forwarding and
// load-use hazard detection (one-cycle stall plus bubble).
module id_ex_fwd_stage #(
    parameter int DATA_WIDTH     = 32,
    parameter int LOGIC_OP_WIDTH = 3,
    parameter int REG_ADDR_WIDTH = 5
) (
    input  logic                      clk_i,
    input  logic                      rst_i,
    input  logic                      id_valid_i,
    input  logic [REG_ADDR_WIDTH-1:0] id_rs_addr_i,
    input  logic [REG_ADDR_WIDTH-1:0] id_rt_addr_i,
    input  logic                      id_use_rs_i,
    input  logic                      id_use_rt_i,
    input  logic [DATA_WIDTH-1:0]     id_rs_data_i,
    input  logic [DATA_WIDTH-1:0]     id_rt_data_i,
    input  logic [DATA_WIDTH-1:0]     id_imm_i,
    input  logic                      id_alusrc_i,
    input  logic [LOGIC_OP_WIDTH-1:0] id_logic_op_i,
    input  logic                      id_sub_i,
    input  logic                      id_arithlogic_i,
    input  logic                      id_slt_sel_i,
    input  logic [REG_ADDR_WIDTH-1:0] id_rd_addr_i,
    input  logic                      id_reg_write_i,
    input  logic                      id_mem_read_i,
    input  logic                      id_mem_write_i,
    input  logic                      exm_reg_write_i,
    input  logic [REG_ADDR_WIDTH-1:0] exm_rd_addr_i,
    input  logic [DATA_WIDTH-1:0]     exm_data_i,
    input  logic                      mw_reg_write_i,
    input  logic [REG_ADDR_WIDTH-1:0] mw_rd_addr_i,
    input  logic [DATA_WIDTH-1:0]     mw_data_i,
    input  logic                      flush_i,
    output logic                      stall_o,
    output logic                      ex_valid_o,
    output logic [LOGIC_OP_WIDTH-1:0] ex_logic_op_o,
    output logic                      ex_sub_o,
    output logic                      ex_arithlogic_o,
    output logic                      ex_slt_sel_o,
    output logic [DATA_WIDTH-1:0]     ex_opd1_o,
    output logic [DATA_WIDTH-1:0]     ex_opd2_o,
    output logic [DATA_WIDTH-1:0]     ex_store_data_o,
    output logic [REG_ADDR_WIDTH-1:0] ex_rd_addr_o,
    output logic                      ex_reg_write_o,
    output logic                      ex_mem_read_o,
    output logic                      ex_mem_write_o
);

    logic                      valid_q;
    logic [REG_ADDR_WIDTH-1:0] rs_addr_q;
    logic [REG_ADDR_WIDTH-1:0] rt_addr_q;
    logic [DATA_WIDTH-1:0]     rs_data_q;
    logic [DATA_WIDTH-1:0]     rt_data_q;
    logic [DATA_WIDTH-1:0]     imm_q;
    logic                      alusrc_q;
    logic [LOGIC_OP_WIDTH-1:0] logic_op_q;
    logic                      sub_q;
    logic                      arithlogic_q;
    logic                      slt_sel_q;
    logic [REG_ADDR_WIDTH-1:0] rd_addr_q;
    logic                      reg_write_q;
    logic                      mem_read_q;
    logic                      mem_write_q;

    logic rs_hit;
    logic rt_hit;
    logic exm_rs_match;
    logic exm_rt_match;
    logic mw_rs_match;
    logic mw_rt_match;
    logic [DATA_WIDTH-1:0] fwd_rs;
    logic [DATA_WIDTH-1:0] fwd_rt;

    // Stall handshake: stall_o is asserted while a load in EX feeds a reader
    // in ID; IF/ID holds that cycle and EX takes a bubble, so the hazard
    // clears itself after exactly one cycle. flush_i always overrides.
    assign rs_hit  = id_use_rs_i && (id_rs_addr_i == ex_rd_addr_o);
    assign rt_hit  = id_use_rt_i && (id_rt_addr_i == ex_rd_addr_o);
    assign stall_o = !flush_i && id_valid_i && ex_valid_o && ex_mem_read_o &&
                     ex_reg_write_o && (ex_rd_addr_o != '0) && (rs_hit || rt_hit);

    // Register 0 never forwards, so it always reads the registered zero.
    assign exm_rs_match = exm_reg_write_i && (exm_rd_addr_i == rs_addr_q) && (rs_addr_q != '0);
    assign exm_rt_match = exm_reg_write_i && (exm_rd_addr_i == rt_addr_q) && (rt_addr_q != '0);
    assign mw_rs_match  = mw_reg_write_i  && (mw_rd_addr_i  == rs_addr_q) && (rs_addr_q != '0);
    assign mw_rt_match  = mw_reg_write_i  && (mw_rd_addr_i  == rt_addr_q) && (rt_addr_q != '0);

    assign fwd_rs = exm_rs_match ? exm_data_i : (mw_rs_match ? mw_data_i : rs_data_q);
    assign fwd_rt = exm_rt_match ? exm_data_i : (mw_rt_match ? mw_data_i : rt_data_q);

    assign ex_opd1_o       = fwd_rs;
    assign ex_opd2_o       = alusrc_q ? imm_q : fwd_rt;
    assign ex_store_data_o = fwd_rt;

    assign ex_valid_o      = valid_q;
    assign ex_logic_op_o   = logic_op_q;
    assign ex_sub_o        = sub_q;
    assign ex_arithlogic_o = arithlogic_q;
    assign ex_slt_sel_o    = slt_sel_q;
    assign ex_rd_addr_o    = rd_addr_q;
    assign ex_reg_write_o  = reg_write_q && valid_q;
    assign ex_mem_read_o   = mem_read_q && valid_q;
    assign ex_mem_write_o  = mem_write_q && valid_q;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            valid_q      <= 1'b0;
            rs_addr_q    <= '0;
            rt_addr_q    <= '0;
            rs_data_q    <= '0;
            rt_data_q    <= '0;
            imm_q        <= '0;
            alusrc_q     <= 1'b0;
            logic_op_q   <= '0;
            sub_q        <= 1'b0;
            arithlogic_q <= 1'b0;
            slt_sel_q    <= 1'b0;
            rd_addr_q    <= '0;
            reg_write_q  <= 1'b0;
            mem_read_q   <= 1'b0;
            mem_write_q  <= 1'b0;
        end else if (flush_i || stall_o) begin
            // Bubble: only the side-effect flags are cleared, data fields hold.
            valid_q     <= 1'b0;
            reg_write_q <= 1'b0;
            mem_read_q  <= 1'b0;
            mem_write_q <= 1'b0;
        end else begin
            valid_q      <= id_valid_i;
            rs_addr_q    <= id_rs_addr_i;
            rt_addr_q    <= id_rt_addr_i;
            rs_data_q    <= id_rs_data_i;
            rt_data_q    <= id_rt_data_i;
            imm_q        <= id_imm_i;
            alusrc_q     <= id_alusrc_i;
            logic_op_q   <= id_logic_op_i;
            sub_q        <= id_sub_i;
            arithlogic_q <= id_arithlogic_i;
            slt_sel_q    <= id_slt_sel_i;
            rd_addr_q    <= id_rd_addr_i;
            reg_write_q  <= id_reg_write_i;
            mem_read_q   <= id_mem_read_i;
            mem_write_q  <= id_mem_write_i;
        end
    end

endmodule

// File: tb/tb_id_ex_fwd_stage.sv
// Directed scoreboard bench for id_ex_fwd_stage: expected EX-stage outputs are
// queued at issue time and popped by a monitor whenever EX holds a valid op.
module tb_id_ex_fwd_stage;

    localparam int DW = 32;
    localparam int LW = 3;
    localparam int AW = 5;
    localparam int EW = 3*DW + AW + 3 + LW + 3;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          id_valid, id_use_rs, id_use_rt, id_alusrc, id_sub, id_arith, id_slt;
    logic          id_rw, id_mr, id_mw;
    logic [AW-1:0] id_rs, id_rt, id_rd;
    logic [DW-1:0] id_rs_data, id_rt_data, id_imm;
    logic [LW-1:0] id_lop;
    logic          exm_rw, mw_rw, flush;
    logic [AW-1:0] exm_rd, mw_rd;
    logic [DW-1:0] exm_data, mw_data;
    logic          stall, ex_valid, ex_sub, ex_arith, ex_slt, ex_rw, ex_mr, ex_mw;
    logic [LW-1:0] ex_lop;
    logic [DW-1:0] ex_opd1, ex_opd2, ex_store;
    logic [AW-1:0] ex_rd;

    logic [EW-1:0] exp_q[$];
    int            n_checks = 0;
    int            n_fail   = 0;

    id_ex_fwd_stage #(.DATA_WIDTH(DW), .LOGIC_OP_WIDTH(LW), .REG_ADDR_WIDTH(AW)) dut (
        .clk_i(clk), .rst_i(rst),
        .id_valid_i(id_valid), .id_rs_addr_i(id_rs), .id_rt_addr_i(id_rt),
        .id_use_rs_i(id_use_rs), .id_use_rt_i(id_use_rt),
        .id_rs_data_i(id_rs_data), .id_rt_data_i(id_rt_data), .id_imm_i(id_imm),
        .id_alusrc_i(id_alusrc), .id_logic_op_i(id_lop), .id_sub_i(id_sub),
        .id_arithlogic_i(id_arith), .id_slt_sel_i(id_slt), .id_rd_addr_i(id_rd),
        .id_reg_write_i(id_rw), .id_mem_read_i(id_mr), .id_mem_write_i(id_mw),
        .exm_reg_write_i(exm_rw), .exm_rd_addr_i(exm_rd), .exm_data_i(exm_data),
        .mw_reg_write_i(mw_rw), .mw_rd_addr_i(mw_rd), .mw_data_i(mw_data),
        .flush_i(flush), .stall_o(stall), .ex_valid_o(ex_valid),
        .ex_logic_op_o(ex_lop), .ex_sub_o(ex_sub), .ex_arithlogic_o(ex_arith),
        .ex_slt_sel_o(ex_slt), .ex_opd1_o(ex_opd1), .ex_opd2_o(ex_opd2),
        .ex_store_data_o(ex_store), .ex_rd_addr_o(ex_rd), .ex_reg_write_o(ex_rw),
        .ex_mem_read_o(ex_mr), .ex_mem_write_o(ex_mw)
    );

    // clock / reset
    always #5 clk = ~clk;

    function automatic logic [EW-1:0] pack(
        input logic [DW-1:0] o1, input logic [DW-1:0] o2, input logic [DW-1:0] st,
        input logic [AW-1:0] rd, input logic rw, input logic mr, input logic mw,
        input logic [LW-1:0] lop, input logic sb, input logic ar, input logic sl);
        return {o1, o2, st, rd, rw, mr, mw, lop, sb, ar, sl};
    endfunction

    function automatic logic [EW-1:0] actual();
        return pack(ex_opd1, ex_opd2, ex_store, ex_rd, ex_rw, ex_mr, ex_mw,
                    ex_lop, ex_sub, ex_arith, ex_slt);
    endfunction

    task automatic check(input string name, input logic [EW-1:0] act, input logic [EW-1:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // driver tasks
    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic set_id(input logic v, input logic [AW-1:0] rs, input logic [AW-1:0] rt,
                          input logic urs, input logic urt,
                          input logic [DW-1:0] rsd, input logic [DW-1:0] rtd,
                          input logic [DW-1:0] imm, input logic asrc,
                          input logic [LW-1:0] lop, input logic sb, input logic ar, input logic sl,
                          input logic [AW-1:0] rd, input logic rw, input logic mr, input logic mw);
        id_valid = v; id_rs = rs; id_rt = rt; id_use_rs = urs; id_use_rt = urt;
        id_rs_data = rsd; id_rt_data = rtd; id_imm = imm; id_alusrc = asrc;
        id_lop = lop; id_sub = sb; id_arith = ar; id_slt = sl;
        id_rd = rd; id_rw = rw; id_mr = mr; id_mw = mw;
    endtask

    task automatic set_fwd(input logic erw, input logic [AW-1:0] erd, input logic [DW-1:0] ed,
                           input logic mrw, input logic [AW-1:0] mrd, input logic [DW-1:0] md);
        exm_rw = erw; exm_rd = erd; exm_data = ed;
        mw_rw = mrw; mw_rd = mrd; mw_data = md;
    endtask

    task automatic id_idle();
        set_id(1'b0, '0, '0, 1'b0, 1'b0, '0, '0, '0, 1'b0, '0, 1'b0, 1'b0, 1'b0, '0, 1'b0, 1'b0, 1'b0);
    endtask

    // monitor: pop and compare whenever EX presents a valid instruction
    always @(negedge clk) begin
        if (!rst && ex_valid) begin
            if (exp_q.size() == 0) begin
                n_checks++;
                n_fail++;
                $display("FAIL unexpected_ex_output: got %h expected none", actual());
            end else begin
                check("ex_outputs", actual(), exp_q.pop_front());
            end
        end
    end

    initial begin
        id_idle();
        set_fwd(1'b0, '0, '0, 1'b0, '0, '0);
        flush = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check("reset_state", {actual(), ex_valid, stall}, '0);
        #1 rst = 1'b0;

        // C1: add r3,r1,r2 (5,7); next cycle EX/MEM forwards 0x100 into r1
        next_cycle();
        set_id(1'b1, 5'd1, 5'd2, 1'b1, 1'b1, 32'd5, 32'd7, 32'h0, 1'b0,
               3'b000, 1'b0, 1'b1, 1'b0, 5'd3, 1'b1, 1'b0, 1'b0);
        exp_q.push_back(pack(32'h100, 32'd7, 32'd7, 5'd3, 1'b1, 1'b0, 1'b0, 3'b000, 1'b0, 1'b1, 1'b0));

        // C2: logic op r6,r4,r2; both stages will target r2 next cycle
        next_cycle();
        set_fwd(1'b1, 5'd1, 32'h100, 1'b0, '0, '0);
        set_id(1'b1, 5'd4, 5'd2, 1'b1, 1'b1, 32'h11, 32'h22, 32'h0, 1'b0,
               3'b011, 1'b0, 1'b0, 1'b0, 5'd6, 1'b1, 1'b0, 1'b0);
        exp_q.push_back(pack(32'h11, 32'hAA, 32'hAA, 5'd6, 1'b1, 1'b0, 1'b0, 3'b011, 1'b0, 1'b0, 1'b0));

        // C3: sub r8,r0,r7; both stages will target r0 next cycle
        next_cycle();
        set_fwd(1'b1, 5'd2, 32'hAA, 1'b1, 5'd2, 32'hBB);
        set_id(1'b1, 5'd0, 5'd7, 1'b1, 1'b1, 32'h0, 32'h77, 32'h0, 1'b0,
               3'b000, 1'b1, 1'b1, 1'b0, 5'd8, 1'b1, 1'b0, 1'b0);
        exp_q.push_back(pack(32'h0, 32'h77, 32'h77, 5'd8, 1'b1, 1'b0, 1'b0, 3'b000, 1'b1, 1'b1, 1'b0));

        // C4: lw r4, 0x10(r1)
        next_cycle();
        set_fwd(1'b1, 5'd0, 32'hCC, 1'b1, 5'd0, 32'hDD);
        set_id(1'b1, 5'd1, 5'd0, 1'b1, 1'b0, 32'h1000, 32'h0, 32'h10, 1'b1,
               3'b000, 1'b0, 1'b1, 1'b0, 5'd4, 1'b1, 1'b1, 1'b0);
        exp_q.push_back(pack(32'h1000, 32'h10, 32'h0, 5'd4, 1'b1, 1'b1, 1'b0, 3'b000, 1'b0, 1'b1, 1'b0));

        // C5: add r5,r4,r6 behind the load -> load-use stall
        next_cycle();
        set_fwd(1'b0, '0, '0, 1'b0, '0, '0);
        set_id(1'b1, 5'd4, 5'd6, 1'b1, 1'b1, 32'h999, 32'h66, 32'h0, 1'b0,
               3'b000, 1'b0, 1'b1, 1'b1, 5'd5, 1'b1, 1'b0, 1'b0);
        #1 check("stall_load_use_rs", {{(EW-1){1'b0}}, stall}, 1);

        // C6: bubble in EX, IF/ID holds the add, stall released
        next_cycle();
        #1;
        check("bubble_valid_rw", {{(EW-2){1'b0}}, ex_valid, ex_rw}, 0);
        check("stall_one_cycle", {{(EW-1){1'b0}}, stall}, 0);
        exp_q.push_back(pack(32'h55, 32'h66, 32'h66, 5'd5, 1'b1, 1'b0, 1'b0, 3'b000, 1'b0, 1'b1, 1'b1));

        // C7: load now in MEM/WB supplies r4; ID issues lw r9
        next_cycle();
        set_fwd(1'b0, '0, '0, 1'b1, 5'd4, 32'h55);
        set_id(1'b1, 5'd0, 5'd0, 1'b1, 1'b0, 32'h0, 32'h0, 32'h4, 1'b1,
               3'b000, 1'b0, 1'b1, 1'b0, 5'd9, 1'b1, 1'b1, 1'b0);
        exp_q.push_back(pack(32'h0, 32'h4, 32'h0, 5'd9, 1'b1, 1'b1, 1'b0, 3'b000, 1'b0, 1'b1, 1'b0));

        // C8: dependent add on r9 with flush -> flush wins, no stall
        next_cycle();
        set_fwd(1'b0, '0, '0, 1'b0, '0, '0);
        set_id(1'b1, 5'd9, 5'd9, 1'b1, 1'b1, 32'h0, 32'h0, 32'h0, 1'b0,
               3'b000, 1'b0, 1'b1, 1'b0, 5'd10, 1'b1, 1'b0, 1'b0);
        flush = 1'b1;
        #1 check("stall_flush_wins", {{(EW-1){1'b0}}, stall}, 0);

        // C9: flushed bubble in EX; ID issues sw r3, 8(r1)
        next_cycle();
        flush = 1'b0;
        #1 check("flush_bubble", {{(EW-3){1'b0}}, ex_valid, ex_rw, ex_mr}, 0);
        set_id(1'b1, 5'd1, 5'd3, 1'b1, 1'b1, 32'h200, 32'h1, 32'h8, 1'b1,
               3'b000, 1'b0, 1'b1, 1'b0, 5'd0, 1'b0, 1'b0, 1'b1);
        exp_q.push_back(pack(32'h200, 32'h8, 32'hDEAD, 5'd0, 1'b0, 1'b0, 1'b1, 3'b000, 1'b0, 1'b1, 1'b0));

        // C10: EX/MEM forwards 0xDEAD to store rt; ID issues lw r4
        next_cycle();
        set_fwd(1'b1, 5'd3, 32'hDEAD, 1'b0, '0, '0);
        set_id(1'b1, 5'd0, 5'd0, 1'b0, 1'b0, 32'h0, 32'h0, 32'h0, 1'b1,
               3'b000, 1'b0, 1'b1, 1'b0, 5'd4, 1'b1, 1'b1, 1'b0);

        // C11: reader of r4 via rt only -> stall; then async reset mid-cycle
        next_cycle();
        set_fwd(1'b0, '0, '0, 1'b0, '0, '0);
        set_id(1'b1, 5'd2, 5'd4, 1'b1, 1'b1, 32'h0, 32'h0, 32'h0, 1'b0,
               3'b000, 1'b0, 1'b1, 1'b0, 5'd11, 1'b1, 1'b0, 1'b0);
        #1 check("stall_load_use_rt", {{(EW-2){1'b0}}, ex_valid, stall}, 2'b11);
        #1 rst = 1'b1;
        #1 check("async_reset_outputs", {actual(), ex_valid, stall}, '0);
        id_idle();
        @(posedge clk);
        #1 rst = 1'b0;

        next_cycle();
        check("post_reset_idle", {{(EW-1){1'b0}}, ex_valid}, 0);
        n_checks++;
        if (exp_q.size() != 0) begin
            n_fail++;
            $display("FAIL scoreboard_drain: got %0d pending expected 0", exp_q.size());
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
